// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART with ready/valid byte interfaces
// Optional feature macro: UART_FRAMING_CHECK_EN (drop frames whose stop bit samples low)
module uart_transceiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  input  logic       serial_in,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  // $clog2(N) bits always hold N-1, the largest count value used
  localparam int CW = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SYM_LAST    = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // ---------------- transmit path ----------------
  logic [0:0]    tx_state_q, tx_state_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;

  assign data_in_ready = (tx_state_q == TX_IDLE);
  // Line is forced high whenever no frame is in flight, so reset idles it immediately
  assign serial_out    = (tx_state_q == TX_SEND) ? tx_shift_q[0] : 1'b1;

  // TX next state: load {stop, data, start} on accept, shift one bit per symbol time
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (data_in_valid) begin
          tx_shift_d = {1'b1, data_in, 1'b0};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == SYM_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  // ---------------- receive path ----------------
  logic [1:0]    sync_q;
  logic          rx_line;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          frame_done;

  assign rx_line        = sync_q[1];
  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;

  // Two-flop synchroniser, preset high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  // RX next state: qualify start at half a bit, then sample each bit centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    frame_done = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_line) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == SAMPLE_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A line already back high at mid-start was only a glitch
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == SYM_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == SYM_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
`ifdef UART_FRAMING_CHECK_EN
          frame_done = rx_line;
`else
          frame_done = 1'b1;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // A completing frame wins over a simultaneous consume and overwrites unread data
    data_out_d = frame_done ? rx_shift_q : data_out_q;
    valid_d    = frame_done | (valid_q & ~data_out_ready);
  end

  // RX state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - self-checking bench for uart_transceiver
module tb_uart_transceiver;

  localparam int CF  = 50_000_000;
  localparam int BR  = 12_500_000;
  localparam int SET = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       serial_in;
  logic       serial_out;

  logic loop_en = 1'b0;
  logic tb_rx = 1'b1;
  assign serial_in = loop_en ? serial_out : tb_rx;

  uart_transceiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .serial_in(serial_in), .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] tx_byte;
    logic [9:0] exp_line;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[5];

  logic [7:0] sb_q[$];
  int b2b_last, b2b_k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line level of bit k of a frame: start 0, data LSB first, then stop
  function automatic logic frame_bit(input logic [7:0] b, input int k, input logic stop);
    if (k == 0) return 1'b0;
    if (k == 9) return stop;
    return b[k-1];
  endfunction

  task automatic wait_valid(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (data_out_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic consume(input string name);
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
    check(name, 32'(data_out_valid), 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      tb_rx = frame_bit(b, k, stop);
      repeat (SET) @(negedge clk);
    end
    tb_rx = 1'b1;
  endtask

  task automatic send_capture(input logic [7:0] b, output logic [9:0] line, output bit ok);
    int k;
    line = '0;
    ok = 0;
    data_in = b;
    data_in_valid = 1'b1;
    for (k = 0; k < 200 && !data_in_ready; k++) @(negedge clk);
    if (!data_in_ready) begin
      data_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int n = 1; n <= 10 * SET; n++) begin
      @(negedge clk);
      if (n == 1) begin
        data_in_valid = 1'b0;
        data_in = ~b;
        check("tx_busy_not_ready", 32'(data_in_ready), 32'd0);
      end
      if (n % SET == 2) line[n / SET] = serial_out;
    end
    ok = 1;
  endtask

  task automatic loop_vector(input string name, input logic [7:0] b,
                             input logic [9:0] exp_line, input logic [7:0] exp_rx);
    logic [9:0] line;
    bit ok;
    send_capture(b, line, ok);
    check({name, "_accepted"}, 32'(ok), 32'd1);
    check({name, "_line"}, 32'(line), 32'(exp_line));
    wait_valid(60, ok);
    check({name, "_rx_valid"}, 32'(ok), 32'd1);
    check({name, "_rx_data"}, 32'(data_out), 32'(exp_rx));
    consume({name, "_consume"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [9:0] el;
    bit ok;
    bit seen;

    vecs[0] = '{8'h64, 10'b1011001000, 8'h64};
    vecs[1] = '{8'h00, 10'b1000000000, 8'h00};
    vecs[2] = '{8'hFF, 10'b1111111110, 8'hFF};
    vecs[3] = '{8'hA5, 10'b1101001010, 8'hA5};
    vecs[4] = '{8'h3C, 10'b1001111000, 8'h3C};

    // 1. reset and idle
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0 || i == 15 || i == 29) begin
        check("rst_serial_out", 32'(serial_out), 32'd1);
        check("rst_in_ready", 32'(data_in_ready), 32'd1);
        check("rst_out_valid", 32'(data_out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h00);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_serial_out", 32'(serial_out), 32'd1);
      check("idle_in_ready", 32'(data_in_ready), 32'd1);
      check("idle_out_valid", 32'(data_out_valid), 32'd0);
      check("idle_data_out", 32'(data_out), 32'h00);
    end

    // 2. table-driven loopback vectors
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      loop_vector($sformatf("vec%0d", i), vecs[i].tx_byte, vecs[i].exp_line, vecs[i].exp_rx);
    end

    // random loopback bytes against the frame model
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      for (int k = 0; k < 10; k++) el[k] = frame_bit(b, k, 1'b1);
      loop_vector($sformatf("rnd_loop%0d", i), b, el, b);
    end

    // 3. back-to-back bytes with data_in_valid held
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          data_in = 8'(i);
          data_in_valid = 1'b1;
          b2b_k = 0;
          while (!data_in_ready && b2b_k < 200) begin
            @(negedge clk);
            b2b_k++;
          end
          check("b2b_ready_seen", 32'(data_in_ready), 32'd1);
          @(posedge clk);
          @(negedge clk);
          if (i > 0) check("b2b_interval", 32'(cyc - b2b_last), 32'(10 * SET + 1));
          b2b_last = cyc;
        end
        data_in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          bit vok;
          wait_valid(200, vok);
          check("b2b_rx_valid", 32'(vok), 32'd1);
          check("b2b_rx_data", 32'(data_out), 32'(i));
          consume("b2b_consume");
        end
      end
    join
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // random bit-banged frames with random gaps, scoreboard on the receive side
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] rb;
          rb = 8'($urandom_range(0, 255));
          sb_q.push_back(rb);
          drive_frame(rb, 1'b1);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          bit vok;
          logic [7:0] eb;
          wait_valid(200, vok);
          check("rnd_rx_valid", 32'(vok), 32'd1);
          eb = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
          check("rnd_rx_data", 32'(data_out), 32'(eb));
          consume("rnd_rx_consume");
        end
      end
    join
    repeat (10) @(negedge clk);

    // 4. overrun
    drive_frame(8'hA5, 1'b1);
    wait_valid(30, ok);
    check("ovr_first_valid", 32'(ok), 32'd1);
    check("ovr_first_data", 32'(data_out), 32'hA5);
    drive_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_valid", 32'(data_out_valid), 32'd1);
    check("ovr_data", 32'(data_out), 32'h3C);
    consume("ovr_consume");

    // 5. glitch and framing
    tb_rx = 1'b0;
    @(negedge clk);
    tb_rx = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_out_valid) seen = 1;
    end
    check("glitch_no_frame", 32'(seen), 32'd0);
    drive_frame(8'h55, 1'b0);
    repeat (15) @(negedge clk);
`ifdef UART_FRAMING_CHECK_EN
    check("framing_dropped_valid", 32'(data_out_valid), 32'd0);
    check("framing_dropped_data", 32'(data_out), 32'h3C);
`else
    check("framing_kept_valid", 32'(data_out_valid), 32'd1);
    check("framing_kept_data", 32'(data_out), 32'h55);
    consume("framing_consume");
`endif
    repeat (10) @(negedge clk);

    // 6. reset in the middle of simultaneous TX and RX frames
    data_in = 8'hAA;
    data_in_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) data_in_valid = 1'b0;
      tb_rx = frame_bit(8'hAA, c / SET, 1'b1);
    end
    check("midrst_tx_busy", 32'(data_in_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midrst_serial_out", 32'(serial_out), 32'd1);
    check("midrst_in_ready", 32'(data_in_ready), 32'd1);
    check("midrst_out_valid", 32'(data_out_valid), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'h00);
    tb_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_out_valid", 32'(data_out_valid), 32'd0);
    drive_frame(8'hC3, 1'b1);
    wait_valid(30, ok);
    check("postrst_rx_valid", 32'(ok), 32'd1);
    check("postrst_rx_data", 32'(data_out), 32'hC3);
    consume("postrst_consume");
    loop_en = 1'b1;
    loop_vector("postrst_loop", 8'hC3, 10'b1110000110, 8'hC3);
    loop_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
